// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  // Sequencer states; the encoding is fixed so debug probes can decode it.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX writes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides what to do with the flag.
//
// Ports:
//   i_id_rs1 / i_id_rs2         source registers of the ID instruction
//   i_id_rs1_use / i_id_rs2_use the ID instruction actually reads that source
//   i_ex_mem_rd                 the EX instruction is a load
//   i_ex_regd                   destination register of the EX instruction
//   o_load_use                  a one-bubble stall is required
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_rs1_use,
  input  logic       i_id_rs2_use,
  input  logic       i_ex_mem_rd,
  input  logic [4:0] i_ex_regd,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_id_rs1_use && (i_id_rs1 == i_ex_regd);
  assign w_rs2_hit  = i_id_rs2_use && (i_id_rs2 == i_ex_regd);
  assign o_load_use = i_ex_mem_rd && (i_ex_regd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage redirects, dmem waits.
// Latency: enables/flushes are combinational (Mealy) from state and inputs; state/counters update on clk_i.
// Backpressure: a dmem wait freezes every stage until dmem_ready_i; a wait of TIMEOUT cycles locks ERROR until reset.
//
// Ports:
//   clk_i, reset_n_i                  clock, async active-low reset
//   id_*_i, ex_mem_rd_i, ex_regd_i    operands for load-use detection
//   mem_redirect_i                    taken branch / JAL resolved in MEM
//   mem_access_i, dmem_ready_i        data-memory handshake
//   *_en_o, *_flush_o                 pipeline register enables and bubble controls
//   pc_sel_redirect_o                 PC loads the redirect target
//   stall_cnt_o                       saturating count of cycles with the PC held
//   err_o                             sticky memory timeout
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_use_i,
  input  logic             id_rs2_use_i,
  input  logic             ex_mem_rd_i,
  input  logic [4:0]       ex_regd_i,
  input  logic             mem_redirect_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             exmem_flush_o,
  output logic             memwb_en_o,
  output logic             pc_sel_redirect_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_pend_redirect;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_mem_wait;

  pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
    .i_id_rs1     (id_rs1_i),
    .i_id_rs2     (id_rs2_i),
    .i_id_rs1_use (id_rs1_use_i),
    .i_id_rs2_use (id_rs2_use_i),
    .i_ex_mem_rd  (ex_mem_rd_i),
    .i_ex_regd    (ex_regd_i),
    .o_load_use   (w_load_use)
  );

  assign w_mem_wait = mem_access_i && !dmem_ready_i;

  always_comb begin
    pc_en_o           = 1'b1;
    ifid_en_o         = 1'b1;
    ifid_flush_o      = 1'b0;
    idex_en_o         = 1'b1;
    idex_flush_o      = 1'b0;
    exmem_en_o        = 1'b1;
    exmem_flush_o     = 1'b0;
    memwb_en_o        = 1'b1;
    pc_sel_redirect_o = 1'b0;

    if (!reset_n_i) begin
      // Hold everything and keep bubbles flowing into the registers while in reset.
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_en_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if ((r_state == ST_RUN) ? w_mem_wait : !dmem_ready_i) begin
            // Memory not done: freeze the whole pipeline, no bubbles.
            pc_en_o    = 1'b0;
            ifid_en_o  = 1'b0;
            idex_en_o  = 1'b0;
            exmem_en_o = 1'b0;
            memwb_en_o = 1'b0;
          end else if ((r_state == ST_RUN) ? mem_redirect_i : r_pend_redirect) begin
            // Redirect squashes the three younger stages, including any load-use victim.
            pc_sel_redirect_o = 1'b1;
            ifid_flush_o      = 1'b1;
            idex_flush_o      = 1'b1;
            exmem_flush_o     = 1'b1;
          end else if (w_load_use) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
          end
        end
        default: begin
          pc_en_o    = 1'b0;
          ifid_en_o  = 1'b0;
          idex_en_o  = 1'b0;
          exmem_en_o = 1'b0;
          memwb_en_o = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state         <= ST_RUN;
      r_wait_cnt      <= '0;
      r_pend_redirect <= 1'b0;
      r_stall_cnt     <= '0;
    end else begin
      if (!pc_en_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      case (r_state)
        ST_RUN: begin
          if (w_mem_wait) begin
            r_state         <= ST_MEM_WAIT;
            r_wait_cnt      <= WC_W'(1);
            // Remember the redirect; it is applied when memory finally completes.
            r_pend_redirect <= mem_redirect_i;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready_i) begin
            // Ready beats a coincident timeout.
            r_state         <= ST_RUN;
            r_wait_cnt      <= '0;
            r_pend_redirect <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt >= WC_LAST) begin
              r_state <= ST_ERROR;
            end
          end
        end
        default: begin
          r_state <= ST_ERROR;
        end
      endcase
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign err_o       = (r_state == ST_ERROR);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Latency: inputs applied mid-cycle, outputs sampled 1 time unit later, state advanced on posedge.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // Output vector order: pc_en ifid_en ifid_fl idex_en idex_fl exmem_en exmem_fl memwb_en pc_sel
  localparam logic [8:0] V_RUN   = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] V_FRZ   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_LU    = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] V_REDIR = 9'b1_1_1_1_1_1_1_1_1;
  localparam logic [8:0] V_RST   = 9'b0_0_1_0_1_0_1_0_0;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [4:0]    id_rs1_i = '0, id_rs2_i = '0, ex_regd_i = '0;
  logic          id_rs1_use_i = 0, id_rs2_use_i = 0, ex_mem_rd_i = 0;
  logic          mem_redirect_i = 0, mem_access_i = 0, dmem_ready_i = 0;
  logic          pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o;
  logic          exmem_en_o, exmem_flush_o, memwb_en_o, pc_sel_redirect_o, err_o;
  logic [CW-1:0] stall_cnt_o;
  logic [8:0]    outv;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, spec-level.
  bit m_waiting, m_err, m_pend;
  int m_waits, m_stalls;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_regd_i(ex_regd_i),
    .mem_redirect_i(mem_redirect_i), .mem_access_i(mem_access_i), .dmem_ready_i(dmem_ready_i),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .ifid_flush_o(ifid_flush_o),
    .idex_en_o(idex_en_o), .idex_flush_o(idex_flush_o),
    .exmem_en_o(exmem_en_o), .exmem_flush_o(exmem_flush_o), .memwb_en_o(memwb_en_o),
    .pc_sel_redirect_o(pc_sel_redirect_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  assign outv = {pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
                 exmem_en_o, exmem_flush_o, memwb_en_o, pc_sel_redirect_o};

  function automatic bit model_lu();
    int d = ex_regd_i;
    return ex_mem_rd_i && d != 0 &&
           ((id_rs1_use_i && int'(id_rs1_i) == d) || (id_rs2_use_i && int'(id_rs2_i) == d));
  endfunction

  function automatic logic [8:0] model_out();
    if (!reset_n_i) return V_RST;
    if (m_err) return V_FRZ;
    if (!m_waiting) begin
      if (mem_access_i && !dmem_ready_i) return V_FRZ;
      if (mem_redirect_i) return V_REDIR;
      if (model_lu()) return V_LU;
      return V_RUN;
    end
    if (!dmem_ready_i) return V_FRZ;
    if (m_pend) return V_REDIR;
    if (model_lu()) return V_LU;
    return V_RUN;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_err = 0; m_pend = 0; m_waits = 0; m_stalls = 0;
  endtask

  task automatic set_in(input bit acc, input bit rdy, input bit redir, input bit mrd,
                        input int regd, input int rs1, input int rs2, input bit u1, input bit u2);
    mem_access_i = acc; dmem_ready_i = rdy; mem_redirect_i = redir; ex_mem_rd_i = mrd;
    ex_regd_i = 5'(regd); id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2);
    id_rs1_use_i = u1; id_rs2_use_i = u2;
    #1;
  endtask

  task automatic clear_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; the model sees the same inputs the DUT saw.
  task automatic tick();
    logic [8:0] o;
    o = model_out();
    @(posedge clk_i);
    if (reset_n_i) begin
      if (o[8] == 1'b0 && m_stalls < CNT_MAX) m_stalls++;
      if (!m_err) begin
        if (!m_waiting) begin
          if (mem_access_i && !dmem_ready_i) begin
            m_waiting = 1; m_waits = 1; m_pend = mem_redirect_i;
          end
        end else if (dmem_ready_i) begin
          m_waiting = 0; m_pend = 0; m_waits = 0;
        end else begin
          m_waits++;
          if (m_waits >= TMO) begin m_err = 1; m_waiting = 0; end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    clear_in();
    model_reset();
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    clear_in();
    model_reset();
    n_tests++;
    if (outv !== V_RST) begin n_fail++; $display("FAIL reset_outputs got %b want %b", outv, V_RST); end
    n_tests++;
    if (stall_cnt_o !== '0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got cnt=%0d err=%b want cnt=0 err=0", stall_cnt_o, err_o);
    end
    do_reset();
    n_tests++;
    if (outv !== V_RUN) begin n_fail++; $display("FAIL run_default got %b want %b", outv, V_RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(0, 0, 0, 1, 5, 0, 5, 0, 1);
    n_tests++;
    if (outv !== V_LU) begin n_fail++; $display("FAIL load_use_outputs got %b want %b", outv, V_LU); end
    tick();
    clear_in();
    n_tests++;
    if (outv !== V_RUN || stall_cnt_o !== CW'(1)) begin
      n_fail++; $display("FAIL load_use_after got %b cnt=%0d want %b cnt=1", outv, stall_cnt_o, V_RUN);
    end
  endtask

  task automatic test_x0_load();
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 0, 1, 1);
    n_tests++;
    if (outv !== V_RUN) begin n_fail++; $display("FAIL x0_load got %b want %b", outv, V_RUN); end
    tick();
    n_tests++;
    if (stall_cnt_o !== '0) begin n_fail++; $display("FAIL x0_load_cnt got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    set_in(0, 0, 1, 1, 7, 7, 0, 1, 0);
    n_tests++;
    if (outv !== V_REDIR) begin n_fail++; $display("FAIL redirect_outputs got %b want %b", outv, V_REDIR); end
    tick();
    clear_in();
    n_tests++;
    if (stall_cnt_o !== '0) begin n_fail++; $display("FAIL redirect_cnt got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 0, (c == 0), 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (outv !== V_FRZ) begin n_fail++; $display("FAIL mem_wait_c%0d got %b want %b", c, outv, V_FRZ); end
      tick();
    end
    // Ready cycle with a load-use present: pending redirect must win.
    set_in(1, 1, 0, 1, 3, 3, 0, 1, 0);
    n_tests++;
    if (outv !== V_REDIR) begin n_fail++; $display("FAIL mem_wait_exit got %b want %b", outv, V_REDIR); end
    n_tests++;
    if (stall_cnt_o !== CW'(3)) begin n_fail++; $display("FAIL mem_wait_cnt got %0d want 3", stall_cnt_o); end
    tick();
    clear_in();
    n_tests++;
    if (outv !== V_RUN || err_o !== 1'b0) begin
      n_fail++; $display("FAIL mem_wait_after got %b err=%b want %b err=0", outv, err_o, V_RUN);
    end
  endtask

  task automatic test_exit_load_use();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 0, 1, 9, 9, 0, 1, 0);
    n_tests++;
    if (outv !== V_LU) begin n_fail++; $display("FAIL exit_load_use got %b want %b", outv, V_LU); end
    tick();
    clear_in();
    n_tests++;
    if (outv !== V_RUN || stall_cnt_o !== CW'(2)) begin
      n_fail++; $display("FAIL exit_load_use_after got %b cnt=%0d want %b cnt=2", outv, stall_cnt_o, V_RUN);
    end
  endtask

  task automatic test_ready_at_timeout();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < TMO - 1; c++) tick();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (outv !== V_RUN) begin n_fail++; $display("FAIL ready_at_timeout got %b want %b", outv, V_RUN); end
    tick();
    clear_in();
    n_tests++;
    if (err_o !== 1'b0 || outv !== V_RUN) begin
      n_fail++; $display("FAIL ready_at_timeout_after got err=%b %b want err=0 %b", err_o, outv, V_RUN);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < TMO; c++) begin
      n_tests++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_early c=%0d got err=%b want 0", c, err_o); end
      tick();
    end
    set_in(0, 1, 1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (err_o !== 1'b1 || outv !== V_FRZ || stall_cnt_o !== CW'(TMO)) begin
      n_fail++;
      $display("FAIL timeout_error got err=%b %b cnt=%0d want err=1 %b cnt=%0d", err_o, outv, stall_cnt_o, V_FRZ, TMO);
    end
    for (int c = 0; c < 16; c++) tick();
    n_tests++;
    if (err_o !== 1'b1 || stall_cnt_o !== CW'(CNT_MAX)) begin
      n_fail++; $display("FAIL timeout_sticky_sat got err=%b cnt=%0d want err=1 cnt=%0d", err_o, stall_cnt_o, CNT_MAX);
    end
    // Asynchronous reset out of ERROR, between clock edges.
    #2;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (err_o !== 1'b0 || stall_cnt_o !== '0 || outv !== V_RST) begin
      n_fail++; $display("FAIL error_async_reset got err=%b cnt=%0d %b want err=0 cnt=0 %b", err_o, stall_cnt_o, outv, V_RST);
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    #2;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (err_o !== 1'b0 || stall_cnt_o !== '0 || outv !== V_RST) begin
      n_fail++; $display("FAIL async_reset got err=%b cnt=%0d %b want err=0 cnt=0 %b", err_o, stall_cnt_o, outv, V_RST);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    clear_in();
    n_tests++;
    if (outv !== V_RUN) begin n_fail++; $display("FAIL async_reset_release got %b want %b", outv, V_RUN); end
    tick();
    n_tests++;
    if (outv !== V_RUN || stall_cnt_o !== '0) begin
      n_fail++; $display("FAIL async_reset_run got %b cnt=%0d want %b cnt=0", outv, stall_cnt_o, V_RUN);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      set_in(($urandom % 3) == 0, $urandom % 2, ($urandom % 4) == 0, $urandom % 2,
             $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 2, $urandom % 2);
      n_tests++;
      if (outv !== model_out() || int'(stall_cnt_o) != m_stalls || err_o !== logic'(m_err)) begin
        n_fail++;
        if (errs < 10) $display("FAIL random c=%0d got %b cnt=%0d err=%b want %b cnt=%0d err=%b",
                                c, outv, stall_cnt_o, err_o, model_out(), m_stalls, m_err);
        errs++;
      end
      tick();
      if (m_err && ($urandom % 4) == 0) do_reset();
    end
  endtask

  initial begin
    model_reset();
    #3;
    test_reset();
    test_load_use();
    test_x0_load();
    test_redirect();
    test_mem_wait();
    test_exit_load_use();
    test_ready_at_timeout();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
